// File: rtl/btn_ctrl_pkg.sv
// Shared types and constants for the debounced button event controller.
package btn_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } deb_state_t;

    localparam int unsigned N_BTN_DEFAULT           = 4;
    // 10 ms of stable samples at 100 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

    // Fold an index in [0, 2n) back into [0, n).
    function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/btn_debounce_arbiter_if.sv
// Press-event valid/ready channel plus the sticky drop flag.
interface btn_debounce_arbiter_if #(
    parameter int unsigned N_BTN = 4
) ();
    localparam int unsigned ID_W = $clog2(N_BTN);

    logic            evt_valid;
    logic [ID_W-1:0] evt_id;
    logic            evt_ready;
    logic            evt_drop;

    modport master (
        output evt_valid,
        output evt_id,
        output evt_drop,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        input  evt_drop,
        output evt_ready
    );
endinterface

// File: rtl/btn_debounce_arbiter_debounce_fsm.sv
// One button channel: stability counter FSM, registered level and a press pulse
// on the cycle the level is accepted as pressed.
module debounce_fsm
    import btn_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press_c
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level   <= level_d;
        end
    end

    // The counter holds how many consecutive samples have disagreed with the accepted level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn) begin
                    state_d = WAIT_PRESS;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_PRESS: begin
                if (!btn) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!btn) begin
                    state_d = WAIT_RELEASE;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_RELEASE: begin
                if (btn) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == PRESSED) || (state_d == WAIT_RELEASE);
    end

endmodule

// File: rtl/btn_debounce_arbiter.sv
// N debounced buttons sharing one press-event slot, granted round-robin
// from already-registered pending bits.
module btn_debounce_arbiter
    import btn_ctrl_pkg::*;
#(
    parameter int unsigned N_BTN           = N_BTN_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_BTN-1:0]      btn_sync,
    output logic [N_BTN-1:0]      btn_level,
    btn_debounce_arbiter_if.master evt
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned ID_W  = $clog2(N_BTN);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(N_BTN - 1);
    localparam logic [ID_W-1:0] ID_ONE  = ID_W'(1);

    logic [N_BTN-1:0] press_c;
    logic [N_BTN-1:0] pending_q, pending_d;
    logic [N_BTN-1:0] grant_c;
    logic [ID_W-1:0]  rr_q, rr_d;
    logic [ID_W-1:0]  winner_c;
    logic [ID_W-1:0]  id_d;
    logic             found_c;
    logic             slot_free_c;
    logic             valid_d;
    logic             drop_d;
    int unsigned      idx_c;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_fsm #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk     (clk),
            .rst     (rst),
            .btn     (btn_sync[i]),
            .level   (btn_level[i]),
            .press_c (press_c[i])
        );
    end

    // First pending channel at or after rr_q, wrapping.
    always_comb begin
        found_c  = 1'b0;
        winner_c = '0;
        idx_c    = 0;
        for (int unsigned k = 0; k < N_BTN; k++) begin
            idx_c = rr_wrap(32'(rr_q) + k, N_BTN);
            if (!found_c && pending_q[idx_c]) begin
                found_c  = 1'b1;
                winner_c = ID_W'(idx_c);
            end
        end
    end

    // Slot reload, pending update and drop detection.
    always_comb begin
        slot_free_c = !evt.evt_valid || evt.evt_ready;
        grant_c     = '0;
        valid_d     = evt.evt_valid;
        id_d        = evt.evt_id;
        rr_d        = rr_q;
        if (slot_free_c) begin
            if (found_c) begin
                valid_d           = 1'b1;
                id_d              = winner_c;
                grant_c[winner_c] = 1'b1;
                rr_d              = (winner_c == ID_LAST) ? '0 : (winner_c + ID_ONE);
            end else begin
                valid_d = 1'b0;
            end
        end
        // A press on a channel whose pending bit is already set is lost.
        pending_d = (pending_q & ~grant_c) | (press_c & ~pending_q);
        drop_d    = evt.evt_drop | (|(press_c & pending_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q     <= '0;
            rr_q          <= '0;
            evt.evt_valid <= 1'b0;
            evt.evt_id    <= '0;
            evt.evt_drop  <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            rr_q          <= rr_d;
            evt.evt_valid <= valid_d;
            evt.evt_id    <= id_d;
            evt.evt_drop  <= drop_d;
        end
    end

endmodule

// File: tb/tb_btn_debounce_arbiter.sv
// Directed and random stimulus against a run-length / queue reference model.
module tb_btn_debounce_arbiter;

    localparam int NB = 4;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_sync;
    logic [NB-1:0] btn_level;

    btn_debounce_arbiter_if #(.N_BTN(NB)) evt_bus ();

    btn_debounce_arbiter #(
        .N_BTN           (NB),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_sync  (btn_sync),
        .btn_level (btn_level),
        .evt       (evt_bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: accepted level, run length of disagreeing samples, pending set, slot.
    bit [NB-1:0] m_lvl;
    int          m_run [NB];
    bit [NB-1:0] m_pend;
    bit          m_valid;
    int          m_id;
    int          m_rr;
    bit          m_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lvl   = '0;
        m_pend  = '0;
        m_valid = 1'b0;
        m_id    = 0;
        m_rr    = 0;
        m_drop  = 1'b0;
        for (int i = 0; i < NB; i++) m_run[i] = 0;
    endtask

    task automatic model_step();
        bit [NB-1:0] old_p;
        int w;
        if (rst) begin
            model_reset();
            return;
        end
        old_p = m_pend;
        if (!m_valid || evt_bus.evt_ready) begin
            w = -1;
            for (int k = 0; k < NB; k++) begin
                if (w < 0 && m_pend[(m_rr + k) % NB]) w = (m_rr + k) % NB;
            end
            if (w >= 0) begin
                m_valid   = 1'b1;
                m_id      = w;
                m_pend[w] = 1'b0;
                m_rr      = (w + 1) % NB;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int i = 0; i < NB; i++) begin
            if (btn_sync[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DC) begin
                    m_lvl[i] = ~m_lvl[i];
                    m_run[i] = 0;
                    if (m_lvl[i]) begin
                        if (old_p[i]) m_drop = 1'b1;
                        else          m_pend[i] = 1'b1;
                    end
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("btn_level", 32'(btn_level), 32'(m_lvl));
        chk("evt_valid", 32'(evt_bus.evt_valid), 32'(m_valid));
        if (m_valid) chk("evt_id", 32'(evt_bus.evt_id), 32'(m_id));
        chk("evt_drop", 32'(evt_bus.evt_drop), 32'(m_drop));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_valid", 32'(evt_bus.evt_valid), 32'd0);
        chk("rst_level", 32'(btn_level), 32'd0);
        tick();
        rst = 1'b0;
    endtask

    int          n_evt;
    int          last_id;
    int          hold [NB];

    initial begin
        rst               = 1'b1;
        btn_sync          = '0;
        evt_bus.evt_ready = 1'b0;
        model_reset();
        ticks(2);
        chk("reset_valid", 32'(evt_bus.evt_valid), 32'd0);
        chk("reset_id",    32'(evt_bus.evt_id),    32'd0);
        chk("reset_drop",  32'(evt_bus.evt_drop),  32'd0);
        chk("reset_level", 32'(btn_level),         32'd0);
        rst = 1'b0;
        tick();

        // Single press on channel 2
        btn_sync[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("press_level_early", 32'(btn_level[2]), 32'd0);
        end
        tick();
        chk("press_level_rise", 32'(btn_level[2]), 32'd1);
        chk("press_no_evt_yet", 32'(evt_bus.evt_valid), 32'd0);
        tick();
        chk("press_valid", 32'(evt_bus.evt_valid), 32'd1);
        chk("press_id",    32'(evt_bus.evt_id),    32'd2);
        evt_bus.evt_ready = 1'b1;
        tick();
        chk("press_consumed", 32'(evt_bus.evt_valid), 32'd0);
        evt_bus.evt_ready = 1'b0;
        btn_sync[2] = 1'b0;
        ticks(3);
        chk("release_level_early", 32'(btn_level[2]), 32'd1);
        tick();
        chk("release_level_fall", 32'(btn_level[2]), 32'd0);
        ticks(3);
        chk("release_no_evt", 32'(evt_bus.evt_valid), 32'd0);

        // Glitch shorter than the debounce window, on press and on release
        btn_sync[0] = 1'b1;
        ticks(3);
        btn_sync[0] = 1'b0;
        ticks(5);
        chk("glitch_press_level", 32'(btn_level[0]), 32'd0);
        chk("glitch_press_evt",   32'(evt_bus.evt_valid), 32'd0);
        evt_bus.evt_ready = 1'b1;
        btn_sync[0] = 1'b1;
        ticks(6);
        btn_sync[0] = 1'b0;
        ticks(3);
        btn_sync[0] = 1'b1;
        ticks(5);
        chk("glitch_release_level", 32'(btn_level[0]), 32'd1);
        btn_sync[0] = 1'b0;
        ticks(6);

        // Round-robin from a fresh pointer
        do_reset();
        evt_bus.evt_ready = 1'b1;
        btn_sync = 4'b1011;
        ticks(4);
        tick();
        chk("rr_first_id",  32'(evt_bus.evt_id), 32'd0);
        tick();
        chk("rr_second_id", 32'(evt_bus.evt_id), 32'd1);
        tick();
        chk("rr_third_id",  32'(evt_bus.evt_id), 32'd3);
        tick();
        chk("rr_drained",   32'(evt_bus.evt_valid), 32'd0);
        btn_sync = '0;
        ticks(6);
        btn_sync = 4'b1001;
        ticks(5);
        chk("rr_wrap_first",  32'(evt_bus.evt_id), 32'd0);
        tick();
        chk("rr_wrap_second", 32'(evt_bus.evt_id), 32'd3);
        btn_sync = '0;
        ticks(6);

        // Backpressure: slot holds id 1, channel 2 pending, re-press of 2 is dropped
        evt_bus.evt_ready = 1'b0;
        btn_sync[1] = 1'b1;
        tick();
        btn_sync[2] = 1'b1;
        ticks(4);
        chk("bp_valid", 32'(evt_bus.evt_valid), 32'd1);
        chk("bp_id",    32'(evt_bus.evt_id),    32'd1);
        btn_sync[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_id_hold", 32'(evt_bus.evt_id), 32'd1);
        end
        btn_sync[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_id_hold", 32'(evt_bus.evt_id), 32'd1);
        end
        chk("bp_drop", 32'(evt_bus.evt_drop), 32'd1);
        evt_bus.evt_ready = 1'b1;
        tick();
        chk("bp_next_id", 32'(evt_bus.evt_id), 32'd2);
        tick();
        chk("bp_only_two", 32'(evt_bus.evt_valid), 32'd0);
        btn_sync = '0;
        ticks(6);
        chk("bp_drop_sticky", 32'(evt_bus.evt_drop), 32'd1);

        // Reset with an event held, one pending and one channel mid-debounce
        evt_bus.evt_ready = 1'b0;
        btn_sync[0] = 1'b1;
        ticks(5);
        btn_sync[1] = 1'b1;
        ticks(4);
        btn_sync[3] = 1'b1;
        ticks(2);
        rst = 1'b1;
        btn_sync = '0;
        model_reset();
        #1;
        chk("async_rst_valid", 32'(evt_bus.evt_valid), 32'd0);
        chk("async_rst_id",    32'(evt_bus.evt_id),    32'd0);
        chk("async_rst_drop",  32'(evt_bus.evt_drop),  32'd0);
        chk("async_rst_level", 32'(btn_level),         32'd0);
        tick();
        rst = 1'b0;
        evt_bus.evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_no_evt", 32'(evt_bus.evt_valid), 32'd0);
        end

        // Bounce train on channel 3 then a steady press
        n_evt   = 0;
        last_id = -1;
        for (int c = 0; c < 20; c++) begin
            btn_sync[3] = ((c / 2) % 2) == 0;
            tick();
            if (evt_bus.evt_valid) begin n_evt++; last_id = int'(evt_bus.evt_id); end
        end
        btn_sync[3] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (evt_bus.evt_valid) begin n_evt++; last_id = int'(evt_bus.evt_id); end
        end
        chk("bounce_evt_count", 32'(n_evt),   32'd1);
        chk("bounce_evt_id",    32'(last_id), 32'd3);
        btn_sync = '0;
        ticks(6);

        // Random levels held for random spans, random backpressure
        for (int i = 0; i < NB; i++) hold[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NB; i++) begin
                if (hold[i] == 0) begin
                    btn_sync[i] = 1'($urandom_range(0, 1));
                    hold[i]     = int'($urandom_range(1, 12));
                end else begin
                    hold[i]--;
                end
            end
            evt_bus.evt_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
